cpu_halt_ctrl: RTL and testbench
================================

// Module: cpu_halt_ctrl
// PURPOSE
// - Power-state controller directly downstream of the instruction decoder's HALT/SLP execution.
// - Consumes halt_req/sleep_req pulses and gates the CPU step enable; on SLP also stops the oscillator.
// - Releases the core when an enabled interrupt is pending, with an oscillator settle delay after SLP.
// PARAMETERS
// - OSC_SETTLE_CYCLES  default 16  clk cycles to hold the core after oscillator restart (0 = no delay).
// - HALT_CNT_W         default 32  width of halt_ticks (optional counter).
// PORTS
// - clk                in   1               system clock; the only clock.
// - reset_n            in   1               asynchronous, active-low reset.
// - clk_en             in   1               CPU tick strobe; never high on two consecutive clk cycles.
// - halt_req           in   1               one-clk pulse when HALT completes.
// - sleep_req          in   1               one-clk pulse when SLP completes.
// - interrupt_pending  in   1               level, OR of the masked interrupt factor flags.
// - int_enable         in   1               CPU I flag.
// - cpu_step_en        out  1               core may advance this cycle.
// - osc_en             out  1               oscillator / clk_en generator enable.
// - halted             out  1               state == HALT.
// - sleeping           out  1               state == SLEEP or SETTLE.
// - wake               out  1               one-clk pulse on the return to RUN.
// - halt_ticks         out  HALT_CNT_W      clk_en ticks spent in HALT (see CONFIGURATION).
// BEHAVIOUR
// - Reset (async, reset_n low):
//   - state=RUN; osc_en=1; halted=0; sleeping=0; wake=0; settle counter=0; halt_ticks=0.
//   - cpu_step_en=0 while reset_n is low.
// - cpu_step_en = (state==RUN) & clk_en & reset_n. Combinational from registered state; 0-cycle gating.
// - RUN:
//   - sleep_req -> SLEEP.
//   - else halt_req -> HALT.
//   - Both in the same cycle -> SLEEP (SLP wins).
//   - Requests are sampled on every clk, independent of clk_en.
// - HALT:
//   - osc_en=1, halted=1.
//   - On a clk edge where clk_en & interrupt_pending & int_enable -> RUN, wake=1 for one clk.
//   - If interrupt_pending is already high at entry, HALT lasts exactly one clk_en tick.
//   - int_enable=0: HALT persists indefinitely (hardware-accurate); only reset exits.
//   - halt_req/sleep_req are ignored while not in RUN.
// - SLEEP:
//   - osc_en=0, sleeping=1.
//   - Wake condition (interrupt_pending & int_enable) is evaluated on every clk, because clk_en is dead.
//   - Wake with OSC_SETTLE_CYCLES>0 -> SETTLE, counter loaded with OSC_SETTLE_CYCLES-1.
//   - Wake with OSC_SETTLE_CYCLES==0 -> RUN directly, wake pulse.
// - SETTLE:
//   - osc_en=1, sleeping=1, cpu_step_en=0.
//   - Counter decrements every clk; the edge where counter==0 -> RUN, wake=1.
//   - Total delay from wake condition to RUN: OSC_SETTLE_CYCLES+1 clk.
//   - Interrupt deassertion during SETTLE does not abort; the wake completes.
// - Counter width: $clog2(OSC_SETTLE_CYCLES+1), minimum 1; no wrap, holds at 0.
// - Reset mid-HALT/SLEEP/SETTLE: immediate RUN, osc_en=1; no wake pulse.
// CONFIGURATION
// - Macro CPU_HALT_TICK_COUNT_EN:
//   - Defined: halt_ticks increments on each clk_en tick while state==HALT, cleared only by reset.
//     Saturates at all-ones.
//   - Undefined: halt_ticks tied to 0 and no counter flops are synthesized.
// STRUCTURE
// - Shared package cpu_power_pkg: typedef enum logic [1:0] {PWR_RUN, PWR_HALT, PWR_SLEEP, PWR_SETTLE} pwr_state_t.
//   The decoder and debug views reuse it.
// - One sub-module, osc_settle_timer: load/decrement/done down-counter parameterised by OSC_SETTLE_CYCLES.
// - FSM and output decode stay in cpu_halt_ctrl.
// TESTING
// 1. Reset release, clk_en every 4 clk, no requests -> cpu_step_en mirrors clk_en; osc_en=1; wake never pulses.
// 2. halt_req; 10 clk_en ticks with int_enable=1, interrupt_pending=0; then interrupt_pending=1
//    -> cpu_step_en=0 for all 10 ticks; halted=1; RUN on the next clk_en edge; wake high 1 clk;
//    halt_ticks=11 with CPU_HALT_TICK_COUNT_EN defined.
// 3. halt_req with int_enable=0, interrupt_pending=1 for 100 clk -> halted stays 1; cpu_step_en 0 throughout.
// 4. sleep_req, OSC_SETTLE_CYCLES=16; interrupt_pending=1 at clk N with clk_en held 0
//    -> osc_en 0 until N, rises at N+1; cpu_step_en blocked until RUN at N+17; wake at N+17.
// 5. halt_req and sleep_req in the same clk -> state SLEEP, osc_en=0, halted=0.
// 6. reset_n low mid-SETTLE (counter=5) -> state RUN, osc_en=1 asynchronously; wake=0;
//    after reset_n rises, cpu_step_en follows clk_en.

Source files
------------

// File: rtl/cpu_power_pkg.sv
// Shared power-state definitions for the CPU halt/sleep controller and its
// decoder / debug views.
//   pwr_state_t   : RUN / HALT / SLEEP / SETTLE encoding
//   settle_cnt_w  : width of the oscillator settle counter (minimum 1 bit)
package cpu_power_pkg;

    typedef enum logic [1:0] {PWR_RUN, PWR_HALT, PWR_SLEEP, PWR_SETTLE} pwr_state_t;

    function automatic int settle_cnt_w(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cpu_halt_ctrl_if.sv
// Handshake bundle between the CPU core/decoder and the halt controller.
//   master : core side; drives tick strobe, HALT/SLP pulses, interrupt state
//   slave  : controller side; drives step enable, oscillator enable, status,
//            wake pulse and the HALT tick count
interface cpu_halt_ctrl_if #(
    parameter int HALT_CNT_W = 32
);
    logic                  clk_en;
    logic                  halt_req;
    logic                  sleep_req;
    logic                  interrupt_pending;
    logic                  int_enable;
    logic                  cpu_step_en;
    logic                  osc_en;
    logic                  halted;
    logic                  sleeping;
    logic                  wake;
    logic [HALT_CNT_W-1:0] halt_ticks;

    modport master (
        output clk_en, halt_req, sleep_req, interrupt_pending, int_enable,
        input  cpu_step_en, osc_en, halted, sleeping, wake, halt_ticks
    );

    modport slave (
        input  clk_en, halt_req, sleep_req, interrupt_pending, int_enable,
        output cpu_step_en, osc_en, halted, sleeping, wake, halt_ticks
    );
endinterface

// File: rtl/osc_settle_timer.sv
// Oscillator settle down-counter.
//   clk, reset_n : clock, async active-low reset (count clears to 0)
//   load         : load OSC_SETTLE_CYCLES-1
//   dec          : decrement by one per clk; holds at 0, never wraps
//   done         : count is 0
module osc_settle_timer
    import cpu_power_pkg::*;
#(
    parameter int OSC_SETTLE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic done
);
    localparam int CW = settle_cnt_w(OSC_SETTLE_CYCLES);
    // With a zero settle time the timer is never loaded; keep the load
    // value legal anyway.
    localparam logic [CW-1:0] LOAD_VAL =
        CW'((OSC_SETTLE_CYCLES > 0) ? OSC_SETTLE_CYCLES - 1 : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= LOAD_VAL;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/cpu_halt_ctrl.sv
// CPU power-state controller downstream of HALT/SLP execution.
//   clk, reset_n : system clock, async active-low reset
//   bus (slave)  : clk_en / halt_req / sleep_req / interrupt_pending /
//                  int_enable in; cpu_step_en / osc_en / halted / sleeping /
//                  wake / halt_ticks out
// HALT gates the core step enable until an enabled interrupt arrives on a
// clk_en tick. SLP additionally stops the oscillator; wake-up is evaluated
// every clk and is followed by an OSC_SETTLE_CYCLES hold before RUN.
// Optional macro CPU_HALT_TICK_COUNT_EN enables the saturating halt_ticks
// counter; otherwise halt_ticks is tied to 0.
module cpu_halt_ctrl
    import cpu_power_pkg::*;
#(
    parameter int OSC_SETTLE_CYCLES = 16,
    parameter int HALT_CNT_W        = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    cpu_halt_ctrl_if.slave  bus
);
    pwr_state_t state, state_nxt;
    logic       wake_q, wake_nxt;
    logic       tmr_load, tmr_done;
    logic       wake_cond;

    assign wake_cond = bus.interrupt_pending & bus.int_enable;

    osc_settle_timer #(
        .OSC_SETTLE_CYCLES (OSC_SETTLE_CYCLES)
    ) u_settle (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .dec     (state == PWR_SETTLE),
        .done    (tmr_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= PWR_RUN;
            wake_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            wake_q <= wake_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wake_nxt  = 1'b0;
        tmr_load  = 1'b0;
        case (state)
            PWR_RUN: begin
                // SLP wins over a simultaneous HALT.
                if (bus.sleep_req)
                    state_nxt = PWR_SLEEP;
                else if (bus.halt_req)
                    state_nxt = PWR_HALT;
            end
            PWR_HALT: begin
                if (bus.clk_en && wake_cond) begin
                    state_nxt = PWR_RUN;
                    wake_nxt  = 1'b1;
                end
            end
            PWR_SLEEP: begin
                // clk_en is dead while the oscillator is off.
                if (wake_cond) begin
                    if (OSC_SETTLE_CYCLES == 0) begin
                        state_nxt = PWR_RUN;
                        wake_nxt  = 1'b1;
                    end else begin
                        state_nxt = PWR_SETTLE;
                        tmr_load  = 1'b1;
                    end
                end
            end
            PWR_SETTLE: begin
                // Committed wake: interrupt deassertion does not abort.
                if (tmr_done) begin
                    state_nxt = PWR_RUN;
                    wake_nxt  = 1'b1;
                end
            end
            default: state_nxt = PWR_RUN;
        endcase
    end

    assign bus.cpu_step_en = (state == PWR_RUN) & bus.clk_en & reset_n;
    assign bus.osc_en      = (state != PWR_SLEEP);
    assign bus.halted      = (state == PWR_HALT);
    assign bus.sleeping    = (state == PWR_SLEEP) | (state == PWR_SETTLE);
    assign bus.wake        = wake_q;

`ifdef CPU_HALT_TICK_COUNT_EN
    logic [HALT_CNT_W-1:0] ticks;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ticks <= '0;
        else if (state == PWR_HALT && bus.clk_en && ticks != '1)
            ticks <= ticks + 1'b1;
    end

    assign bus.halt_ticks = ticks;
`else
    assign bus.halt_ticks = '0;
`endif
endmodule

// File: tb/tb_cpu_halt_ctrl.sv
module tb_cpu_halt_ctrl;
    localparam int OSC = 16;
    localparam int HW  = 8;
    localparam longint TMAX = (64'sd1 << HW) - 1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cpu_halt_ctrl_if #(.HALT_CNT_W(HW)) bus ();

    cpu_halt_ctrl #(.OSC_SETTLE_CYCLES(OSC), .HALT_CNT_W(HW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: mode flags plus remaining settle cycles.
    bit     m_halt, m_sleep, m_wake;
    int     m_settle;
    longint m_ticks;

    function automatic void m_reset();
        m_halt = 0; m_sleep = 0; m_wake = 0; m_settle = 0; m_ticks = 0;
    endfunction

    function automatic bit m_running();
        return !m_halt && !m_sleep && m_settle == 0;
    endfunction

    function automatic void m_adv(bit ce, bit hr, bit sr, bit ip, bit ie);
        bit w = 0;
        if (m_running()) begin
            if (sr) m_sleep = 1;
            else if (hr) m_halt = 1;
        end else if (m_halt) begin
            if (ce && m_ticks < TMAX) m_ticks++;
            if (ce && ip && ie) begin m_halt = 0; w = 1; end
        end else if (m_sleep) begin
            if (ip && ie) begin
                m_sleep = 0;
                if (OSC == 0) w = 1; else m_settle = OSC;
            end
        end else begin
            m_settle--;
            if (m_settle == 0) w = 1;
        end
        m_wake = w;
    endfunction

    function automatic longint exp_ticks();
`ifdef CPU_HALT_TICK_COUNT_EN
        return m_ticks;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit ce, input bit hr, input bit sr, input bit ip, input bit ie);
        @(negedge clk);
        bus.clk_en = ce; bus.halt_req = hr; bus.sleep_req = sr;
        bus.interrupt_pending = ip; bus.int_enable = ie;
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_step"},  bus.cpu_step_en, m_running() && bus.clk_en && reset_n);
        chk({tag, "_osc"},   bus.osc_en,      !m_sleep);
        chk({tag, "_halt"},  bus.halted,      m_halt);
        chk({tag, "_sleep"}, bus.sleeping,    m_sleep || m_settle != 0);
        chk({tag, "_wake"},  bus.wake,        m_wake);
        chk({tag, "_ticks"}, bus.halt_ticks,  exp_ticks());
    endtask

    task automatic cyc(input string tag, input bit ce, input bit hr, input bit sr, input bit ip, input bit ie);
        drive(ce, hr, sr, ip, ie);
        check_model(tag);
        m_adv(ce, hr, sr, ip, ie);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.clk_en = 0; bus.halt_req = 0; bus.sleep_req = 0;
        bus.interrupt_pending = 0; bus.int_enable = 0;
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
    endtask

    typedef struct {
        bit ce, hr, sr, ip, ie;
        bit step, osc, hlt, slp, wk;
    } vec_t;
    vec_t tbl[11];

    initial begin
        bit ce, hr, sr, ip, ie;
        tbl[0]  = '{1,0,0,0,1, 1,1,0,0,0};
        tbl[1]  = '{0,1,0,0,1, 0,1,0,0,0};
        tbl[2]  = '{1,0,0,0,1, 0,1,1,0,0};
        tbl[3]  = '{0,0,0,1,1, 0,1,1,0,0};
        tbl[4]  = '{1,0,0,1,1, 0,1,1,0,0};
        tbl[5]  = '{0,0,0,0,1, 0,1,0,0,1};
        tbl[6]  = '{1,1,1,0,1, 1,1,0,0,0};
        tbl[7]  = '{0,0,0,1,0, 0,0,0,1,0};
        tbl[8]  = '{0,1,0,1,0, 0,0,0,1,0};
        tbl[9]  = '{0,0,0,1,1, 0,0,0,1,0};
        tbl[10] = '{1,0,0,0,1, 0,1,0,1,0};

        reset_n = 1'b0;
        bus.clk_en = 0; bus.halt_req = 0; bus.sleep_req = 0;
        bus.interrupt_pending = 0; bus.int_enable = 0;
        m_reset();
        #2;
        chk("rst_step", bus.cpu_step_en, 0);
        chk("rst_osc",  bus.osc_en, 1);
        chk("rst_halt", bus.halted, 0);
        chk("rst_wake", bus.wake, 0);
        chk("rst_ticks", bus.halt_ticks, 0);
        bus.clk_en = 1; #1;
        chk("rst_step_gated", bus.cpu_step_en, 0);
        do_reset();

        // Test 1: clk_en every 4 clk, no requests.
        for (int i = 0; i < 16; i++) begin
            cyc("t1", (i % 4) == 0, 0, 0, 0, 0);
            chk("t1_mirror", bus.cpu_step_en, (i % 4) == 0);
        end

        // Table vectors.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].ce, tbl[i].hr, tbl[i].sr, tbl[i].ip, tbl[i].ie);
            chk($sformatf("vec%0d_step", i),  bus.cpu_step_en, tbl[i].step);
            chk($sformatf("vec%0d_osc", i),   bus.osc_en,      tbl[i].osc);
            chk($sformatf("vec%0d_halt", i),  bus.halted,      tbl[i].hlt);
            chk($sformatf("vec%0d_sleep", i), bus.sleeping,    tbl[i].slp);
            chk($sformatf("vec%0d_wake", i),  bus.wake,        tbl[i].wk);
            m_adv(tbl[i].ce, tbl[i].hr, tbl[i].sr, tbl[i].ip, tbl[i].ie);
        end

        // Test 2: 10 HALT ticks without interrupt, then exit on the 11th.
        do_reset();
        cyc("t2_req", 0, 1, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            cyc("t2_hold", (i % 2) == 0, 0, 0, 0, 1);
            chk("t2_halted", bus.halted, 1);
            chk("t2_nostep", bus.cpu_step_en, 0);
        end
        cyc("t2_ip", 0, 0, 0, 1, 1);
        cyc("t2_exit", 1, 0, 0, 1, 1);
        cyc("t2_run", 0, 0, 0, 1, 1);
        chk("t2_wake", bus.wake, 1);
        chk("t2_halted_clr", bus.halted, 0);
`ifdef CPU_HALT_TICK_COUNT_EN
        chk("t2_ticks11", bus.halt_ticks, 11);
`else
        chk("t2_ticks0", bus.halt_ticks, 0);
`endif
        cyc("t2_wake_off", 1, 0, 0, 1, 1);
        chk("t2_wake_1clk", bus.wake, 0);

        // Test 3: HALT with int_enable=0 persists.
        do_reset();
        cyc("t3_req", 0, 1, 0, 1, 0);
        for (int i = 0; i < 100; i++) begin
            cyc("t3", (i % 2) == 0, 0, 0, 1, 0);
            chk("t3_halted", bus.halted, 1);
            chk("t3_nostep", bus.cpu_step_en, 0);
        end

        // Test 4: SLEEP, wake at N, RUN at N+17.
        do_reset();
        cyc("t4_req", 0, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) cyc("t4_sleep", 0, 0, 0, 0, 1);
        cyc("t4_N", 0, 0, 0, 1, 1);
        chk("t4_osc_N", bus.osc_en, 0);
        for (int k = 1; k <= 17; k++) begin
            // interrupt drops right away: the wake must still complete
            cyc("t4_settle", k == 17, 0, 0, 0, 1);
            if (k == 1)  chk("t4_osc_N1", bus.osc_en, 1);
            if (k == 16) chk("t4_still_settle", bus.sleeping, 1);
            if (k < 17)  chk("t4_blocked", bus.cpu_step_en, 0);
        end
        chk("t4_wake_N17", bus.wake, 1);
        chk("t4_step_N17", bus.cpu_step_en, 1);

        // Test 5: simultaneous HALT and SLP.
        do_reset();
        cyc("t5_req", 0, 1, 1, 0, 1);
        cyc("t5", 0, 0, 0, 0, 1);
        chk("t5_sleep", bus.sleeping, 1);
        chk("t5_osc", bus.osc_en, 0);
        chk("t5_halt", bus.halted, 0);

        // Test 6: async reset in SETTLE with counter at 5.
        do_reset();
        cyc("t6_req", 0, 0, 1, 0, 1);
        cyc("t6_N", 0, 0, 0, 1, 1);
        for (int k = 1; k <= 11; k++) cyc("t6_settle", 0, 0, 0, 1, 1);
        reset_n = 1'b0;
        bus.clk_en = 1'b1;
        #1;
        chk("t6_rst_osc", bus.osc_en, 1);
        chk("t6_rst_sleep", bus.sleeping, 0);
        chk("t6_rst_halt", bus.halted, 0);
        chk("t6_rst_wake", bus.wake, 0);
        chk("t6_rst_step", bus.cpu_step_en, 0);
        @(negedge clk);
        bus.clk_en = 1'b0;
        reset_n = 1'b1;
        m_reset();
        for (int i = 0; i < 8; i++) begin
            cyc("t6_post", (i % 2) == 1, 0, 0, 1, 1);
            chk("t6_follow", bus.cpu_step_en, (i % 2) == 1);
        end

        // Randomized run against the model.
        do_reset();
        ce = 0; ip = 0; ie = 1;
        for (int i = 0; i < 3000; i++) begin
            ce = ce ? 1'b0 : 1'($urandom_range(0, 1));
            hr = ($urandom_range(0, 15) == 0);
            sr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 9) == 0) ip = ~ip;
            if ($urandom_range(0, 19) == 0) ie = ~ie;
            cyc("rnd", ce, hr, sr, ip, ie);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
